l0p_link_mgmt_controller: RTL and testbench

- Parametrised successor to the combinational Link Management DLLP field decoder.
- Registers and validates incoming Link Management DLLPs (type 0x28, mgmt type 0x00), classifies L0p commands, and runs the local L0p width-change negotiation.
- Negotiation covers the request/response handshake, timeout, bounded retry, and priority-based preemption.
- Sits between the DLLP receive path and the LTSSM/L0p width logic.

---
 rtl/l0p_link_mgmt_controller.sv | 156 +++++++++++++++
 tb/tb_l0p_link_mgmt_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l0p_link_mgmt_controller.sv
// Link Management DLLP decoder and local L0p width-change negotiator.
// DLLPs are registered once; all DLLP-driven effects appear in the following cycle.
module l0p_link_mgmt_controller #(
    parameter logic [2:0]  MAX_WIDTH_CODE = 3'd4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_MAX      = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dllp_valid,
    input  logic [31:0]      dllp_data,
    input  logic             local_req_valid,
    output logic             local_req_ready,
    input  logic [2:0]       local_req_width,
    input  logic             local_req_priority,
    output logic             tx_req_send,
    output logic [2:0]       tx_req_width,
    output logic             remote_req_valid,
    output logic [2:0]       remote_req_width,
    output logic             remote_req_priority,
    output logic             width_update,
    output logic [2:0]       current_width,
    output logic             local_done,
    output logic [1:0]       local_status,
    output logic [CNT_W-1:0] err_count,
    output logic             busy
);
    localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned RW = $clog2(RETRY_MAX + 2);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

    typedef enum logic [0:0] {IDLE, WAIT_RSP} state_t;

    state_t        state;
    logic          d_valid;
    logic [31:0]   d_data;
    logic [TW-1:0] timer;
    logic [RW-1:0] retries;
    logic [2:0]    lat_width;
    logic          lat_priority;

    logic          is_lm, well_formed, is_req, is_rsp, is_bad;
    logic [3:0]    cmd;
    logic [2:0]    d_width;
    logic          d_priority, rsp_accept;

    always_comb begin
        cmd         = d_data[14:11];
        d_width     = d_data[2:0];
        d_priority  = d_data[15];
        rsp_accept  = (d_data[10:8] == 3'b000);
        is_lm       = d_valid && (d_data[31:24] == 8'h28);
        well_formed = (d_data[23:16] == 8'h00) && (d_width <= MAX_WIDTH_CODE)
                      && ((cmd == 4'h1) || (cmd == 4'h2));
        is_req      = is_lm && well_formed && (cmd == 4'h1);
        is_rsp      = is_lm && well_formed && (cmd == 4'h2);
        is_bad      = is_lm && !well_formed;
    end

    assign local_req_ready = (state == IDLE);
    assign busy            = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid <= 1'b0;
            d_data  <= '0;
        end else begin
            d_valid <= dllp_valid;
            d_data  <= dllp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state               <= IDLE;
            timer               <= '0;
            retries             <= '0;
            lat_width           <= '0;
            lat_priority        <= 1'b0;
            tx_req_send         <= 1'b0;
            tx_req_width        <= '0;
            remote_req_valid    <= 1'b0;
            remote_req_width    <= '0;
            remote_req_priority <= 1'b0;
            width_update        <= 1'b0;
            current_width       <= MAX_WIDTH_CODE;
            local_done          <= 1'b0;
            local_status        <= '0;
            err_count           <= '0;
        end else begin
            tx_req_send      <= 1'b0;
            remote_req_valid <= 1'b0;
            width_update     <= 1'b0;
            local_done       <= 1'b0;

            if (is_bad && (err_count != '1))
                err_count <= err_count + 1'b1;

            case (state)
                IDLE: begin
                    if (is_req) begin
                        remote_req_valid    <= 1'b1;
                        remote_req_width    <= d_width;
                        remote_req_priority <= d_priority;
                    end
                    if (local_req_valid) begin
                        lat_width    <= local_req_width;
                        lat_priority <= local_req_priority;
                        tx_req_send  <= 1'b1;
                        tx_req_width <= local_req_width;
                        timer        <= '0;
                        retries      <= '0;
                        state        <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    // Matching response outranks preemption and timeout in the same cycle.
                    if (is_rsp && (d_width == lat_width)) begin
                        local_done <= 1'b1;
                        state      <= IDLE;
                        if (rsp_accept) begin
                            local_status  <= 2'b00;
                            current_width <= lat_width;
                            width_update  <= (current_width != lat_width);
                        end else begin
                            local_status <= 2'b01;
                        end
                    end else if (is_req && d_priority && !lat_priority) begin
                        local_done          <= 1'b1;
                        local_status        <= 2'b11;
                        remote_req_valid    <= 1'b1;
                        remote_req_width    <= d_width;
                        remote_req_priority <= d_priority;
                        state               <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        if (retries < RETRY_LAST) begin
                            retries      <= retries + 1'b1;
                            timer        <= '0;
                            tx_req_send  <= 1'b1;
                            tx_req_width <= lat_width;
                        end else begin
                            local_done   <= 1'b1;
                            local_status <= 2'b10;
                            state        <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l0p_link_mgmt_controller.sv
// Scoreboard bench: stimulus queues expected pulse events, a negedge monitor pops and compares them.
module tb_l0p_link_mgmt_controller;
    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dllp_valid = 1'b0;
    logic [31:0] dllp_data = '0;
    logic        local_req_valid = 1'b0;
    logic        local_req_ready;
    logic [2:0]  local_req_width = '0;
    logic        local_req_priority = 1'b0;
    logic        tx_req_send;
    logic [2:0]  tx_req_width;
    logic        remote_req_valid;
    logic [2:0]  remote_req_width;
    logic        remote_req_priority;
    logic        width_update;
    logic [2:0]  current_width;
    logic        local_done;
    logic [1:0]  local_status;
    logic [15:0] err_count;
    logic        busy;

    l0p_link_mgmt_controller #(
        .MAX_WIDTH_CODE(3'd4),
        .TIMEOUT_CYCLES(TO),
        .RETRY_MAX(2),
        .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .dllp_valid(dllp_valid), .dllp_data(dllp_data),
        .local_req_valid(local_req_valid), .local_req_ready(local_req_ready),
        .local_req_width(local_req_width), .local_req_priority(local_req_priority),
        .tx_req_send(tx_req_send), .tx_req_width(tx_req_width),
        .remote_req_valid(remote_req_valid), .remote_req_width(remote_req_width),
        .remote_req_priority(remote_req_priority),
        .width_update(width_update), .current_width(current_width),
        .local_done(local_done), .local_status(local_status),
        .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        logic     tx;
        logic     rem;
        logic     done;
        logic     wupd;
        logic [2:0] tx_w;
        logic [2:0] rem_w;
        logic     rem_p;
        logic [1:0] status;
        logic [2:0] cur_w;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int c, input logic tx, input logic [2:0] tx_w,
                        input logic rem, input logic [2:0] rem_w, input logic rem_p,
                        input logic done, input logic [1:0] st, input logic wupd,
                        input logic [2:0] cur_w);
        ev_t e;
        e.cyc = c; e.tx = tx; e.tx_w = tx_w; e.rem = rem; e.rem_w = rem_w;
        e.rem_p = rem_p; e.done = done; e.status = st; e.wupd = wupd; e.cur_w = cur_w;
        exp_q.push_back(e);
    endtask

    // Monitor: any pulse output must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && (tx_req_send || remote_req_valid || local_done || width_update)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", {tx_req_send, remote_req_valid, local_done, width_update}, 0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_flags", {tx_req_send, remote_req_valid, local_done, width_update},
                      {e.tx, e.rem, e.done, e.wupd});
                if (e.tx)   check("tx_req_width", tx_req_width, e.tx_w);
                if (e.rem)  check("remote_req", {remote_req_width, remote_req_priority}, {e.rem_w, e.rem_p});
                if (e.done) check("local_status", local_status, e.status);
                if (e.done) check("current_width", current_width, e.cur_w);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_dllp(input logic [31:0] d);
        dllp_valid = 1'b1; dllp_data = d;
        tick(1);
        dllp_valid = 1'b0; dllp_data = '0;
    endtask

    task automatic local_req(input logic [2:0] w, input logic p);
        check("ready_before_req", local_req_ready, 1);
        local_req_valid = 1'b1; local_req_width = w; local_req_priority = p;
        tick(1);
        local_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check("rst_current_width", current_width, 4);
        check("rst_err_count", err_count, 0);
        check("rst_ready", local_req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_pulses", {tx_req_send, remote_req_valid, local_done, width_update, local_status}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);

        // Remote Request, width 4, priority 0
        push(cyc + 2, 0, 0, 1, 3'd4, 0, 0, 0, 0, 0);
        send_dllp(32'h2800_0804);
        tick(3);
        check("err_after_req", err_count, 0);

        // Local width 2, accepted: 4 -> 2 with width_update
        push(cyc + 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd2, 1'b0);
        check("busy_wait", busy, 1);
        check("ready_wait", local_req_ready, 0);
        push(cyc + 2, 0, 0, 0, 0, 0, 1, 2'b00, 1, 3'd2);
        send_dllp(32'h2800_1002);
        tick(3);
        check("cur_after_accept", current_width, 2);
        check("busy_after_accept", busy, 0);

        // Rejected response: width unchanged
        push(cyc + 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd2, 1'b0);
        push(cyc + 2, 0, 0, 0, 0, 0, 1, 2'b01, 0, 3'd2);
        send_dllp(32'h2800_1102);
        tick(3);

        // Accept at the same width: no width_update
        push(cyc + 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd2, 1'b0);
        push(cyc + 2, 0, 0, 0, 0, 0, 1, 2'b00, 0, 3'd2);
        send_dllp(32'h2800_1002);
        tick(3);

        // Non-matching response ignored, matching one completes
        push(cyc + 1, 1, 3'd1, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd1, 1'b0);
        send_dllp(32'h2800_1004);
        tick(2);
        check("busy_nonmatch", busy, 1);
        check("err_nonmatch", err_count, 0);
        push(cyc + 2, 0, 0, 0, 0, 0, 1, 2'b00, 1, 3'd1);
        send_dllp(32'h2800_1001);
        tick(3);

        // Timeout with two retries
        begin
            int base;
            base = cyc + 1;
            push(base,          1, 3'd3, 0, 0, 0, 0, 0, 0, 0);
            push(base + TO,     1, 3'd3, 0, 0, 0, 0, 0, 0, 0);
            push(base + 2 * TO, 1, 3'd3, 0, 0, 0, 0, 0, 0, 0);
            push(base + 3 * TO, 0, 0, 0, 0, 0, 1, 2'b10, 0, 3'd1);
            local_req(3'd3, 1'b0);
            tick(3 * TO + 4);
            check("busy_after_timeout", busy, 0);
        end

        // Preemption by priority-1 remote request
        push(cyc + 1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd0, 1'b0);
        tick(2);
        push(cyc + 2, 0, 0, 1, 3'd4, 1, 1, 2'b11, 0, 3'd1);
        send_dllp(32'h2800_8804);
        tick(3);
        check("busy_after_preempt", busy, 0);

        // Priority-1 local request: remote dropped
        push(cyc + 1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd0, 1'b1);
        send_dllp(32'h2800_8804);
        tick(3);
        check("busy_not_preempted", busy, 1);
        push(cyc + 2, 0, 0, 0, 0, 0, 1, 2'b00, 1, 3'd0);
        send_dllp(32'h2800_1000);
        tick(3);

        // Malformed Link Management DLLPs, back to back
        send_dllp(32'h2801_0800);
        send_dllp(32'h2800_3805);
        tick(2);
        check("err_two", err_count, 2);
        send_dllp(32'h2800_0807);
        tick(2);
        check("err_three", err_count, 3);
        send_dllp(32'h1000_0000);
        tick(2);
        check("err_other_dllp", err_count, 3);

        // Reset in WAIT_RSP aborts silently
        push(cyc + 1, 1, 3'd2, 0, 0, 0, 0, 0, 0, 0);
        local_req(3'd2, 1'b0);
        tick(2);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", local_req_ready, 1);
        check("arst_current_width", current_width, 4);
        check("arst_err_count", err_count, 0);
        check("arst_pulses", {tx_req_send, local_done, local_status}, 0);
        tick(1);
        rst = 1'b0;
        tick(4 * TO);
        check("busy_after_arst", busy, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
